// File: rtl/axi4_lite_slave_ctrl.sv
// AXI4-Lite slave front-end: turns AW/W/AR handshakes into single-cycle register-file strobes.
// Optional address range check enabled by defining AXIL_ADDR_CHECK_EN.
module axi4_lite_slave_ctrl #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    output logic [1:0]              s_axi_bresp,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [ADDR_WIDTH-1:0]   wr_addr,
    output logic                    wr_en,
    output logic [DATA_WIDTH-1:0]   wr_data,
    output logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic [1:0]              wr_resp,
    output logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_en,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    input  logic [1:0]              rd_resp
);

    localparam int unsigned StrbWidth  = DATA_WIDTH / 8;
    localparam logic [1:0]  RespSlvErr = 2'b10;

`ifdef AXIL_ADDR_CHECK_EN
    localparam bit AddrCheck = 1'b1;
`else
    localparam bit AddrCheck = 1'b0;
`endif

    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        return !AddrCheck || ((a[ADDR_WIDTH-1:6] == '0) && ({28'd0, a[5:2]} < NUM_REGS));
    endfunction

    typedef enum logic [1:0] {StWIdle, StWExec, StWWait, StWResp} wr_state_e;
    typedef enum logic [1:0] {StRIdle, StRExec, StRResp} rd_state_e;

    wr_state_e             wr_state_q, wr_state_d;
    logic                  aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic                  awready_q, awready_d, wready_q, wready_d;
    logic                  bvalid_q, bvalid_d, wr_en_q, wr_en_d;
    logic [1:0]            bresp_q, bresp_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [StrbWidth-1:0]  wr_strb_q, wr_strb_d;

    rd_state_e             rd_state_q, rd_state_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rd_en_q, rd_en_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Outputs are flopped from the next state so every port is a register.
    always_comb begin
        wr_state_d = wr_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_strb_d  = wr_strb_q;
        bresp_d    = bresp_q;
        unique case (wr_state_q)
            StWIdle: begin
                if (s_axi_awvalid && awready_q) begin
                    aw_held_d = 1'b1;
                    wr_addr_d = s_axi_awaddr;
                end
                if (s_axi_wvalid && wready_q) begin
                    w_held_d  = 1'b1;
                    wr_data_d = s_axi_wdata;
                    wr_strb_d = s_axi_wstrb;
                end
                if (aw_held_d && w_held_d) begin
                    wr_state_d = StWExec;
                    aw_held_d  = 1'b0;
                    w_held_d   = 1'b0;
                end
            end
            StWExec: wr_state_d = StWWait;
            StWWait: begin
                bresp_d    = addr_ok(wr_addr_q) ? wr_resp : RespSlvErr;
                wr_state_d = StWResp;
            end
            StWResp: if (s_axi_bready) wr_state_d = StWIdle;
            default: wr_state_d = StWIdle;
        endcase
        awready_d = (wr_state_d == StWIdle) && !aw_held_d;
        wready_d  = (wr_state_d == StWIdle) && !w_held_d;
        wr_en_d   = (wr_state_d == StWExec) && addr_ok(wr_addr_d);
        bvalid_d  = (wr_state_d == StWResp);
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rd_addr_d  = rd_addr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        unique case (rd_state_q)
            StRIdle: begin
                if (s_axi_arvalid && arready_q) begin
                    rd_addr_d  = s_axi_araddr;
                    rd_state_d = StRExec;
                end
            end
            StRExec: begin
                // rd_en_q is low here only when the range check rejected the address.
                rdata_d    = rd_en_q ? rd_data : '0;
                rresp_d    = rd_en_q ? rd_resp : RespSlvErr;
                rd_state_d = StRResp;
            end
            StRResp: if (s_axi_rready) rd_state_d = StRIdle;
            default: rd_state_d = StRIdle;
        endcase
        arready_d = (rd_state_d == StRIdle);
        rd_en_d   = (rd_state_d == StRExec) && addr_ok(rd_addr_d);
        rvalid_d  = (rd_state_d == StRResp);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= StWIdle;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_strb_q  <= '0;
            rd_state_q <= StRIdle;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= '0;
            rdata_q    <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_strb_q  <= wr_strb_d;
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign wr_en         = wr_en_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign wr_strb       = wr_strb_q;
    assign rd_en         = rd_en_q;
    assign rd_addr       = rd_addr_q;

endmodule

// File: tb/tb_axi4_lite_slave_ctrl.sv
// Directed bench for axi4_lite_slave_ctrl with a 16-entry register-file model.
// Build with or without AXIL_ADDR_CHECK_EN; the out-of-range test adapts.
module tb_axi4_lite_slave_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] s_axi_awaddr = '0, s_axi_wdata = '0, s_axi_araddr = '0;
    logic [3:0]  s_axi_wstrb = '0;
    logic        s_axi_awvalid = 1'b0, s_axi_wvalid = 1'b0, s_axi_bready = 1'b0;
    logic        s_axi_arvalid = 1'b0, s_axi_rready = 1'b0;
    logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid;
    logic [1:0]  s_axi_bresp, s_axi_rresp;
    logic [31:0] s_axi_rdata;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_data;
    logic [3:0]  wr_strb;
    logic        wr_en, rd_en;
    logic [1:0]  wr_resp, rd_resp;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;

    always #5 clk = ~clk;

    axi4_lite_slave_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .wr_addr(wr_addr), .wr_en(wr_en), .wr_data(wr_data), .wr_strb(wr_strb),
        .wr_resp(wr_resp), .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
        .rd_resp(rd_resp)
    );

    // Register-file model; responses are garbage outside their valid cycle.
    logic [31:0] regs [16];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) regs[i] <= '0;
            wr_resp <= 2'b11;
        end else begin
            wr_resp <= wr_en ? 2'b00 : 2'b11;
            if (wr_en) begin
                for (int b = 0; b < 4; b++) begin
                    if (wr_strb[b]) regs[wr_addr[5:2]][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end
    assign rd_data = rd_en ? regs[rd_addr[5:2]] : 32'hBAD0BAD0;
    assign rd_resp = rd_en ? 2'b00 : 2'b11;

    always @(posedge clk) begin
        if (wr_en) wr_cnt <= wr_cnt + 1;
        if (rd_en) rd_cnt <= rd_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Cycle counts are relative to the AW/W handshake cycle; -1 means never seen.
    task automatic wait_b(output int en_cyc, output int b_cyc, output logic [1:0] resp);
        en_cyc = -1;
        b_cyc  = -1;
        resp   = 2'b11;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (wr_en && en_cyc < 0) en_cyc = i;
            if (s_axi_bvalid && b_cyc < 0) begin
                b_cyc = i;
                resp  = s_axi_bresp;
            end
            @(posedge clk); #1;
            if (b_cyc >= 0) break;
        end
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic brdy,
                            output int en_cyc, output int b_cyc, output logic [1:0] resp);
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        s_axi_bready  = brdy;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        wait_b(en_cyc, b_cyc, resp);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic rrdy,
                           output int rv_cyc, output logic [31:0] data, output logic [1:0] resp);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        s_axi_rready  = rrdy;
        @(posedge clk); #1;
        s_axi_arvalid = 1'b0;
        rv_cyc = -1;
        data   = 32'hFFFF_FFFF;
        resp   = 2'b11;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (s_axi_rvalid && rv_cyc < 0) begin
                rv_cyc = i;
                data   = s_axi_rdata;
                resp   = s_axi_rresp;
            end
            @(posedge clk); #1;
            if (rv_cyc >= 0) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int          en, bc, rv, n0, r0;
        logic [1:0]  resp, rresp;
        logic [31:0] data;
        logic        bad, bad2;
        int          en4, bc4, rv4;
        logic [1:0]  resp4, rresp4;
        logic [31:0] data4;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst awready", s_axi_awready, 0);
        check_eq("rst wready", s_axi_wready, 0);
        check_eq("rst arready", s_axi_arready, 0);
        check_eq("rst bvalid", s_axi_bvalid, 0);
        check_eq("rst rvalid", s_axi_rvalid, 0);
        check_eq("rst rdata", s_axi_rdata, 0);
        check_eq("rst wr_en", wr_en, 0);
        check_eq("rst rd_en", rd_en, 0);
        rst_n = 1'b1;
        #1 check_eq("rel awready pre-edge", s_axi_awready, 0);
        @(negedge clk);
        check_eq("rel awready", s_axi_awready, 1);
        check_eq("rel wready", s_axi_wready, 1);
        check_eq("rel arready", s_axi_arready, 1);
        @(posedge clk); #1;

        // 1: same-cycle AW/W, then read back
        n0 = wr_cnt;
        do_write(32'h08, 32'hDEADBEEF, 4'hF, 1'b1, en, bc, resp);
        check_eq("t1 wr_en cyc", en, 1);
        check_eq("t1 bvalid cyc", bc, 3);
        check_eq("t1 bresp", resp, 2'b00);
        check_eq("t1 wr_en pulses", wr_cnt - n0, 1);
        check_eq("t1 awready back", s_axi_awready, 1);
        do_read(32'h08, 1'b1, rv, data, rresp);
        check_eq("t1 rvalid cyc", rv, 2);
        check_eq("t1 rdata", data, 32'hDEADBEEF);
        check_eq("t1 rresp", rresp, 2'b00);

        // 2: W three cycles ahead of AW, partial strobe
        do_write(32'h04, 32'hAAAAAAAA, 4'hF, 1'b1, en, bc, resp);
        n0 = wr_cnt;
        s_axi_wdata  = 32'h12345678;
        s_axi_wstrb  = 4'h3;
        s_axi_wvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_wvalid = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (s_axi_wready || !s_axi_awready || wr_en) bad = 1'b1;
            @(posedge clk); #1;
        end
        check_eq("t2 wready held low", bad, 0);
        s_axi_awaddr  = 32'h04;
        s_axi_awvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        wait_b(en, bc, resp);
        check_eq("t2 wr_en cyc", en, 1);
        check_eq("t2 bvalid cyc", bc, 3);
        check_eq("t2 wr_en pulses", wr_cnt - n0, 1);
        do_read(32'h04, 1'b1, rv, data, rresp);
        check_eq("t2 readback", data, 32'hAAAA5678);

        // 3: backpressure on B and R
        do_write(32'h10, 32'h5A5A0001, 4'hF, 1'b0, en, bc, resp);
        check_eq("t3 bvalid cyc", bc, 3);
        n0 = wr_cnt;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!s_axi_bvalid || s_axi_bresp != 2'b00 || s_axi_awready || s_axi_wready) bad = 1'b1;
            @(posedge clk); #1;
        end
        check_eq("t3 b stable", bad, 0);
        check_eq("t3 no extra wr_en", wr_cnt - n0, 0);
        s_axi_bready = 1'b1;
        @(posedge clk); #1;
        s_axi_bready = 1'b0;
        @(negedge clk);
        check_eq("t3 bvalid cleared", s_axi_bvalid, 0);
        check_eq("t3 awready back", s_axi_awready, 1);
        @(posedge clk); #1;
        do_read(32'h10, 1'b0, rv, data, rresp);
        check_eq("t3 rvalid cyc", rv, 2);
        check_eq("t3 rdata", data, 32'h5A5A0001);
        r0 = rd_cnt;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!s_axi_rvalid || s_axi_rdata != 32'h5A5A0001 || s_axi_arready) bad = 1'b1;
            @(posedge clk); #1;
        end
        check_eq("t3 r stable", bad, 0);
        check_eq("t3 no extra rd_en", rd_cnt - r0, 0);
        s_axi_rready = 1'b1;
        @(posedge clk); #1;
        s_axi_rready = 1'b0;
        @(negedge clk);
        check_eq("t3 rvalid cleared", s_axi_rvalid, 0);
        check_eq("t3 arready back", s_axi_arready, 1);
        @(posedge clk); #1;

        // 4: concurrent write and read of the same register
        do_write(32'h0C, 32'h11111111, 4'hF, 1'b1, en, bc, resp);
        fork
            do_write(32'h0C, 32'h22222222, 4'hF, 1'b1, en4, bc4, resp4);
            do_read(32'h0C, 1'b1, rv4, data4, rresp4);
        join
        check_eq("t4 wr_en cyc", en4, 1);
        check_eq("t4 bvalid cyc", bc4, 3);
        check_eq("t4 rvalid cyc", rv4, 2);
        check_eq("t4 old data", data4, 32'h11111111);
        do_read(32'h0C, 1'b1, rv, data, rresp);
        check_eq("t4 new data", data, 32'h22222222);

        // 5: address 0x40
        n0 = wr_cnt;
        do_write(32'h40, 32'hCAFEF00D, 4'hF, 1'b1, en, bc, resp);
        check_eq("t5 bvalid cyc", bc, 3);
        r0 = rd_cnt;
        do_read(32'h40, 1'b1, rv, data, rresp);
        check_eq("t5 rvalid cyc", rv, 2);
`ifdef AXIL_ADDR_CHECK_EN
        check_eq("t5 wr_en suppressed", en, -1);
        check_eq("t5 wr_en pulses", wr_cnt - n0, 0);
        check_eq("t5 bresp", resp, 2'b10);
        check_eq("t5 rd_en suppressed", rd_cnt - r0, 0);
        check_eq("t5 rdata", data, 32'h0);
        check_eq("t5 rresp", rresp, 2'b10);
        do_read(32'h00, 1'b1, rv, data, rresp);
        check_eq("t5 reg0 unchanged", data, 32'h0);
`else
        check_eq("t5 wr_en cyc", en, 1);
        check_eq("t5 wr_en pulses", wr_cnt - n0, 1);
        check_eq("t5 bresp", resp, 2'b00);
        check_eq("t5 rdata alias", data, 32'hCAFEF00D);
        check_eq("t5 rresp", rresp, 2'b00);
        do_read(32'h00, 1'b1, rv, data, rresp);
        check_eq("t5 reg0 written", data, 32'hCAFEF00D);
`endif
        check_eq("t5 reg0 rresp", rresp, 2'b00);

        // 6: reset while B is pending
        do_write(32'h14, 32'h00000077, 4'hF, 1'b0, en, bc, resp);
        check_eq("t6 bvalid cyc", bc, 3);
        #3 rst_n = 1'b0;
        #1;
        check_eq("t6 async bvalid", s_axi_bvalid, 0);
        check_eq("t6 async awready", s_axi_awready, 0);
        check_eq("t6 async arready", s_axi_arready, 0);
        check_eq("t6 async wr_addr", wr_addr, 0);
        @(posedge clk);
        @(negedge clk);
        s_axi_bready = 1'b1;
        rst_n = 1'b1;
        n0 = wr_cnt;
        bad  = 1'b0;
        bad2 = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (s_axi_bvalid || wr_en) bad = 1'b1;
            if (!(s_axi_awready && s_axi_wready && s_axi_arready)) bad2 = 1'b1;
            @(posedge clk); #1;
        end
        check_eq("t6 no stale b/wr_en", bad, 0);
        check_eq("t6 readies back", bad2, 0);
        check_eq("t6 wr_en pulses", wr_cnt - n0, 0);
        do_write(32'h14, 32'h00000099, 4'hF, 1'b1, en, bc, resp);
        check_eq("t6 post-reset wr_en cyc", en, 1);
        check_eq("t6 post-reset bvalid cyc", bc, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
